// File: rtl/ob_writeback_dma.sv
`default_nettype none
// ============================================================================
// Module   : ob_writeback_dma
// Purpose  : Drains Output Buffer rows after a GEMM tile and serialises each
//            row into single-word write beats with a programmable row stride.
// Revision : 1.0 - initial release
// ============================================================================
module ob_writeback_dma #(
   parameter int SYSTOLIC_ARRAY_WIDTH = 16,
   parameter int DATA_WIDTH_ACCUM     = 32,
   parameter int ADDR_WIDTH           = 10,
   parameter int EXT_ADDR_WIDTH       = 32
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                cmd_start,
   input  logic [ADDR_WIDTH-1:0]               cmd_ob_base,
   input  logic [ADDR_WIDTH:0]                 cmd_num_rows,
   input  logic [$clog2(SYSTOLIC_ARRAY_WIDTH):0] cmd_num_cols,
   input  logic [EXT_ADDR_WIDTH-1:0]           cmd_dst_addr,
   input  logic [EXT_ADDR_WIDTH-1:0]           cmd_dst_stride,
   output logic [ADDR_WIDTH-1:0]               axim_rd_addr_out,
   output logic                                axim_rd_en_out,
   input  logic [DATA_WIDTH_ACCUM-1:0]         axim_rd_data_in [SYSTOLIC_ARRAY_WIDTH],
   output logic                                m_wr_valid,
   input  logic                                m_wr_ready,
   output logic [EXT_ADDR_WIDTH-1:0]           m_wr_addr,
   output logic [DATA_WIDTH_ACCUM-1:0]         m_wr_data,
   output logic                                m_wr_last,
   output logic                                busy,
   output logic                                done
);

   localparam int c_col_w = $clog2(SYSTOLIC_ARRAY_WIDTH) + 1;
   localparam int c_idx_w = $clog2(SYSTOLIC_ARRAY_WIDTH);
   localparam int c_bytes = DATA_WIDTH_ACCUM / 8;

   localparam logic [c_col_w-1:0]        c_full_cols = c_col_w'(SYSTOLIC_ARRAY_WIDTH);
   localparam logic [c_col_w-1:0]        c_col_one   = c_col_w'(1);
   localparam logic [ADDR_WIDTH:0]       c_row_one   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0]     c_addr_one  = ADDR_WIDTH'(1);
   localparam logic [EXT_ADDR_WIDTH-1:0] c_byte_step = EXT_ADDR_WIDTH'(c_bytes);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_CAPT = 3'd2,
      S_SEND = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                        r_state;
   state_t                        w_next;

   logic [ADDR_WIDTH:0]           r_num_rows;
   logic [ADDR_WIDTH:0]           r_row;
   logic [c_col_w-1:0]            r_eff_cols;
   logic [c_col_w-1:0]            r_col;
   logic [EXT_ADDR_WIDTH-1:0]     r_stride;
   logic [EXT_ADDR_WIDTH-1:0]     r_row_base;
   logic [ADDR_WIDTH-1:0]         r_rd_addr;
   logic [DATA_WIDTH_ACCUM-1:0]   r_rowreg [SYSTOLIC_ARRAY_WIDTH];

   logic [c_col_w-1:0]            w_cmd_eff_cols;
   logic                          w_col_last;
   logic                          w_row_last;
   logic [EXT_ADDR_WIDTH-1:0]     w_col_off;

   // A column request of zero or wider than the array means "whole row".
   assign w_cmd_eff_cols = (cmd_num_cols == '0 || cmd_num_cols > c_full_cols) ?
                           c_full_cols : cmd_num_cols;
   assign w_col_last     = (r_col + c_col_one) == r_eff_cols;
   assign w_row_last     = (r_row + c_row_one) == r_num_rows;
   assign w_col_off      = EXT_ADDR_WIDTH'(r_col) * c_byte_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next           = r_state;
      axim_rd_en_out   = 1'b0;
      axim_rd_addr_out = r_rd_addr;
      m_wr_valid       = 1'b0;
      m_wr_addr        = '0;
      m_wr_data        = '0;
      m_wr_last        = 1'b0;
      busy             = (r_state != S_IDLE);
      done             = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cmd_start) begin
               w_next = (cmd_num_rows == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            axim_rd_en_out = 1'b1;
            w_next         = S_CAPT;
         end
         S_CAPT: begin
            w_next = S_SEND;
         end
         S_SEND: begin
            m_wr_valid = 1'b1;
            m_wr_addr  = r_row_base + w_col_off;
            m_wr_data  = r_rowreg[r_col[c_idx_w-1:0]];
            m_wr_last  = w_row_last && w_col_last;
            if (m_wr_ready && w_col_last) begin
               w_next = w_row_last ? S_DONE : S_READ;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_num_rows <= '0;
         r_row      <= '0;
         r_eff_cols <= '0;
         r_col      <= '0;
         r_stride   <= '0;
         r_row_base <= '0;
         r_rd_addr  <= '0;
         for (int i = 0; i < SYSTOLIC_ARRAY_WIDTH; i++) begin
            r_rowreg[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_start) begin
                  r_num_rows <= cmd_num_rows;
                  r_eff_cols <= w_cmd_eff_cols;
                  r_stride   <= cmd_dst_stride;
                  r_row_base <= cmd_dst_addr;
                  r_row      <= '0;
                  r_col      <= '0;
                  // Read address only moves when a read will follow; it holds otherwise.
                  if (cmd_num_rows != '0) begin
                     r_rd_addr <= cmd_ob_base;
                  end
               end
            end
            S_CAPT: begin
               for (int i = 0; i < SYSTOLIC_ARRAY_WIDTH; i++) begin
                  r_rowreg[i] <= axim_rd_data_in[i];
               end
            end
            S_SEND: begin
               if (m_wr_ready) begin
                  if (w_col_last) begin
                     r_col      <= '0;
                     r_row      <= r_row + c_row_one;
                     r_row_base <= r_row_base + r_stride;
                     if (!w_row_last) begin
                        r_rd_addr <= r_rd_addr + c_addr_one;
                     end
                  end else begin
                     r_col <= r_col + c_col_one;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ob_writeback_dma.sv
`default_nettype none
// Scoreboard bench for ob_writeback_dma: a buffer model feeds the DUT, expected
// reads/beats are queued at command issue and checked by an independent monitor.
module tb_ob_writeback_dma;
   localparam int W   = 16;
   localparam int DW  = 32;
   localparam int AW  = 10;
   localparam int EAW = 32;
   localparam int CW  = $clog2(W) + 1;

   logic            clk;
   logic            rst_n;
   logic            cmd_start;
   logic [AW-1:0]   cmd_ob_base;
   logic [AW:0]     cmd_num_rows;
   logic [CW-1:0]   cmd_num_cols;
   logic [EAW-1:0]  cmd_dst_addr;
   logic [EAW-1:0]  cmd_dst_stride;
   logic [AW-1:0]   axim_rd_addr_out;
   logic            axim_rd_en_out;
   logic [DW-1:0]   rd_data [W];
   logic            m_wr_valid;
   logic            m_wr_ready;
   logic [EAW-1:0]  m_wr_addr;
   logic [DW-1:0]   m_wr_data;
   logic            m_wr_last;
   logic            busy;
   logic            done;

   ob_writeback_dma #(
      .SYSTOLIC_ARRAY_WIDTH(W), .DATA_WIDTH_ACCUM(DW),
      .ADDR_WIDTH(AW), .EXT_ADDR_WIDTH(EAW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_ob_base(cmd_ob_base),
      .cmd_num_rows(cmd_num_rows), .cmd_num_cols(cmd_num_cols),
      .cmd_dst_addr(cmd_dst_addr), .cmd_dst_stride(cmd_dst_stride),
      .axim_rd_addr_out(axim_rd_addr_out), .axim_rd_en_out(axim_rd_en_out),
      .axim_rd_data_in(rd_data), .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready),
      .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_last(m_wr_last),
      .busy(busy), .done(done)
   );

   typedef struct {
      logic [EAW-1:0] addr;
      logic [DW-1:0]  data;
      logic           last;
   } beat_t;

   logic [DW-1:0] mem [1024][W];
   beat_t         exp_q [$];
   logic [AW-1:0] rd_q [$];
   int            total = 0;
   int            bad = 0;
   int            exp_done = 0;
   int            done_seen = 0;
   bit            rand_ready = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Output Buffer model: one-cycle read latency, garbage on the bus otherwise.
   initial begin
      logic          en;
      logic [AW-1:0] a;
      for (int i = 0; i < W; i++) rd_data[i] = '0;
      forever begin
         @(negedge clk);
         en = axim_rd_en_out;
         a  = axim_rd_addr_out;
         @(posedge clk);
         #1;
         for (int i = 0; i < W; i++) rd_data[i] = en ? mem[a][i] : $urandom;
      end
   end

   initial begin
      m_wr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor / scoreboard
   initial begin
      bit    hold;
      bit    prev_done;
      beat_t prev;
      beat_t e;
      hold = 0;
      prev_done = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 0;
            prev_done = 0;
            continue;
         end
         if (hold) begin
            check("hold_valid", m_wr_valid, 1);
            check("hold_addr", m_wr_addr, prev.addr);
            check("hold_data", m_wr_data, prev.data);
            check("hold_last", m_wr_last, prev.last);
         end
         if (m_wr_valid && m_wr_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", m_wr_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("beat_addr", m_wr_addr, e.addr);
               check("beat_data", m_wr_data, e.data);
               check("beat_last", m_wr_last, e.last);
            end
         end
         hold = m_wr_valid && !m_wr_ready;
         prev.addr = m_wr_addr;
         prev.data = m_wr_data;
         prev.last = m_wr_last;
         if (axim_rd_en_out) begin
            if (rd_q.size() == 0) check("extra_read", axim_rd_addr_out, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("rd_addr", axim_rd_addr_out, rd_q.pop_front());
         end
         if (done) begin
            done_seen++;
            check("done_width", prev_done, 0);
            check("done_beats_left", exp_q.size(), 0);
            check("done_reads_left", rd_q.size(), 0);
         end
         prev_done = done;
      end
   end

   task automatic issue(input logic [AW-1:0] base, input int rows, input int cols,
                        input logic [EAW-1:0] dst, input logic [EAW-1:0] stride,
                        input bit push);
      int            eff;
      int            ra;
      beat_t         b;
      if (push) begin
         eff = (cols == 0 || cols > W) ? W : cols;
         for (int r = 0; r < rows; r++) begin
            ra = (int'(base) + r) % 1024;
            rd_q.push_back(AW'(ra));
            for (int c = 0; c < eff; c++) begin
               b.addr = dst + 32'(r) * stride + 32'(c) * 32'd4;
               b.data = mem[ra][c];
               b.last = (r == rows - 1) && (c == eff - 1);
               exp_q.push_back(b);
            end
         end
         exp_done++;
      end
      @(negedge clk);
      cmd_ob_base    = base;
      cmd_num_rows   = (AW+1)'(rows);
      cmd_num_cols   = CW'(cols);
      cmd_dst_addr   = dst;
      cmd_dst_stride = stride;
      cmd_start      = 1'b1;
      @(negedge clk);
      cmd_start      = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4000; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check("idle_timeout", busy, 0);
      check("beats_left", exp_q.size(), 0);
      check("reads_left", rd_q.size(), 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_valid"}, m_wr_valid, 0);
      check({tag, "_addr"}, m_wr_addr, 0);
      check({tag, "_data"}, m_wr_data, 0);
      check({tag, "_last"}, m_wr_last, 0);
      check({tag, "_rd_en"}, axim_rd_en_out, 0);
      check({tag, "_rd_addr"}, axim_rd_addr_out, 0);
   endtask

   initial begin
      for (int r = 0; r < 1024; r++)
         for (int c = 0; c < W; c++) mem[r][c] = $urandom;
      rst_n = 1'b0;
      cmd_start = 1'b0;
      cmd_ob_base = '0;
      cmd_num_rows = '0;
      cmd_num_cols = '0;
      cmd_dst_addr = '0;
      cmd_dst_stride = '0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;

      // Directed cases with ready tied high
      issue(10'd5, 1, 16, 32'h1000, 32'h0, 1);
      check("busy_after_start", busy, 1);
      wait_idle();
      issue(10'd40, 3, 4, 32'h2000, 32'h100, 1);
      wait_idle();
      issue(10'd1022, 4, 2, 32'h3000, 32'h40, 1);
      wait_idle();

      // Empty command, then a back-to-back full-width command right after DONE
      issue(10'd7, 0, 3, 32'h4000, 32'h10, 1);
      check("zero_rows_done", done, 1);
      issue(10'd9, 1, 0, 32'h5000, 32'h0, 1);
      wait_idle();

      // Start while busy must be ignored
      issue(10'd100, 2, 16, 32'h6000, 32'h80, 1);
      repeat (3) @(negedge clk);
      issue(10'd300, 3, 5, 32'h7000, 32'h10, 0);
      wait_idle();

      // Randomised commands with 50% ready
      rand_ready = 1;
      for (int t = 0; t < 12; t++) begin
         issue(AW'($urandom_range(0, 1023)), $urandom_range(0, 4), $urandom_range(0, 31),
               $urandom, $urandom, 1);
         wait_idle();
      end

      // Reset during SEND: abort with no done, outputs cleared asynchronously
      issue(10'd200, 2, 16, 32'h8000, 32'h100, 1);
      for (int i = 0; i < 100; i++) begin
         if (m_wr_valid) break;
         @(negedge clk);
      end
      check("valid_before_abort", m_wr_valid, 1);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("abort");
      exp_q.delete();
      rd_q.delete();
      exp_done--;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      issue(10'd50, 2, 3, 32'h9000, 32'h20, 1);
      wait_idle();
      rand_ready = 0;

      repeat (4) @(negedge clk);
      check("done_count", done_seen, exp_done);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
